slc: RTL and testbench

SLC -- requirements
Module: slc

---
 rtl/slc.sv | 38 +++
 tb/tb_slc.sv | 124 ++++++++++++
 2 files changed

// File: rtl/slc.sv
// slc: logarithmic barrel rotate-left with a combinational result and a one-cycle registered copy
module slc #(
    parameter int N = 32,
    parameter int K = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [K-1:0] b,
    input  logic         in_valid,
    output logic [N-1:0] r,
    output logic [N-1:0] r_q,
    output logic         out_valid
);
    logic [K:0][N-1:0] s;

    assign s[0] = a;
    assign r    = s[K];

    genvar j;
    generate
        for (j = 0; j < K; j++) begin : g_lvl
            localparam int S = 1 << j;
            assign s[j+1] = b[j] ? {s[j][N-1-S:0], s[j][N-1:N-S]} : s[j];
        end
    endgenerate

    // capture the rotated word on in_valid; out_valid follows in_valid one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) r_q <= r;
        end
    end
endmodule

// File: tb/tb_slc.sv
// tb_slc: scoreboard bench for slc; combinational result checked on drive, registered result checked by a monitor
module tb_slc;
    localparam int N = 32;
    localparam int K = $clog2(N);

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a;
    logic [K-1:0] b;
    logic         in_valid;
    logic [N-1:0] r;
    logic [N-1:0] r_q;
    logic         out_valid;

    int checks = 0;
    int fails  = 0;
    logic [N-1:0] sb [$];

    slc #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .r(r), .r_q(r_q), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] rot(input logic [N-1:0] x, input int n);
        logic [2*N-1:0] d;
        if (n == 0) return x;
        d = {x, x} << n;
        return d[2*N-1:N];
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [N-1:0] x, input logic [K-1:0] n, input logic v, input logic [N-1:0] exp);
        @(negedge clk);
        a = x;
        b = n;
        in_valid = v;
        #1;
        chk("comb_r", r, exp);
        if (v) sb.push_back(exp);
    endtask

    // monitor: pops the scoreboard whenever out_valid is presented, else requires r_q to hold
    initial begin
        logic [N-1:0] last;
        last = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) last = '0;
            else if (out_valid) begin
                if (sb.size() == 0) chk("unexpected_out_valid", {{(N-1){1'b0}}, out_valid}, '0);
                else chk("r_q", r_q, sb.pop_front());
                last = r_q;
            end else chk("r_q_hold", r_q, last);
        end
    end

    initial begin
        logic [N-1:0] walk_exp [5];
        logic [K-1:0] walk_b [5];
        logic [N-1:0] x;
        logic [K-1:0] n;
        walk_b   = '{5'd1, 5'd3, 5'd7, 5'd15, 5'd31};
        walk_exp = '{32'h00000002, 32'h00000008, 32'h00000080, 32'h00008000, 32'h80000000};
        rst_n = 1'b0;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        #2;
        chk("reset_r_q", r_q, '0);
        chk("reset_out_valid", {{(N-1){1'b0}}, out_valid}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) issue(32'h00000001, walk_b[i], 1'b1, walk_exp[i]);
        issue(32'h80000001, 5'd1, 1'b1, 32'h00000003);
        issue(32'h12345678, 5'd4, 1'b1, 32'h23456781);
        issue(32'hDEADBEEF, 5'd0, 1'b1, 32'hDEADBEEF);
        issue(32'h00000001, 5'd31, 1'b1, 32'h80000000);
        issue(32'h0F0F0F0F, 5'd9, 1'b0, rot(32'h0F0F0F0F, 9));
        @(posedge clk);
        #1;
        chk("hold_after_idle", r_q, 32'h80000000);
        chk("idle_out_valid", {{(N-1){1'b0}}, out_valid}, '0);
        issue(32'hA5A5A5A5, 5'd13, 1'b1, rot(32'hA5A5A5A5, 13));
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        chk("pre_reset_out_valid", {{(N-1){1'b0}}, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_r_q", r_q, '0);
        chk("async_reset_out_valid", {{(N-1){1'b0}}, out_valid}, '0);
        chk("r_during_reset", r, rot(32'hA5A5A5A5, 13));
        a = 32'h12345678;
        b = 5'd8;
        #1;
        chk("r_tracks_in_reset", r, 32'h34567812);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            n = K'($urandom_range(0, N - 1));
            issue(x, n, 1'($urandom_range(0, 3) != 0), rot(x, int'(n)));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
